sram_bank_responder: RTL and testbench
======================================

Name: sram_bank_responder

Overview:
- Memory-side responder for the two-wire rw/valid command interface driven by the chip-select controller FSM.
- Accepts one read or write command per valid assertion, applies the programmed latency, then performs the access on a small word array.
- Returns read data with a one-cycle strobe and signals completion with done.
- Sits between the controller FSM and the storage array in the memory datapath.

Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 2, address width; array depth is 2**ADDR_W words
- READ_LAT, 2, cycles from accept edge to read capture; range 1..15
- WRITE_LAT, 1, cycles from accept edge to array write; range 1..15

Ports:
- clk  input  1  single system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- valid  input  1  command present; level signal from the controller, may be held for many cycles
- rw  input  1  command type, sampled with valid: 1 = write, 0 = read
- addr  input  ADDR_W  word address, sampled at accept
- wdata  input  DATA_W  write data, sampled at accept
- ready  output  1  responder can accept a command this cycle
- busy  output  1  a command is in flight (WAIT or DONE state)
- rdata  output  DATA_W  read data; holds the last read value
- rdata_valid  output  1  one-cycle strobe, rdata newly updated
- done  output  1  one-cycle strobe, command completed
- protocol_err  output  1  sticky error flag

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, armed = 1, counter = 0.
  - Every array word = 0; rdata = 0.
  - ready = 1; busy, rdata_valid, done and protocol_err = 0.
  - Reset asserted mid-operation aborts the command; no array write takes place.
- States (2-bit encoding): IDLE=00, RD_WAIT=01, WR_WAIT=10, DONE=11.
- Accept condition: state == IDLE, armed == 1 and valid == 1, sampled at rising edge N.
  - Captures rw, addr and wdata into internal registers.
  - Loads counter with (rw ? WRITE_LAT : READ_LAT) - 1.
  - Moves to WR_WAIT if rw = 1, otherwise RD_WAIT.
  - Clears armed.
- Re-arming: armed returns to 1 at any edge where valid == 0. One transaction per valid assertion; a held valid never retriggers.
- RD_WAIT / WR_WAIT:
  - counter decrements each edge while nonzero.
  - At the edge where counter == 0: WR_WAIT writes the captured wdata to array[addr]; RD_WAIT loads rdata from array[addr]. State then goes to DONE.
  - Result: the access occurs at edge N + LAT.
- DONE: lasts exactly one cycle, then IDLE.
  - done = 1 for that cycle.
  - rdata_valid = 1 only if the command was a read.
- Outputs are registered or decoded from state only; no combinational path from inputs.
  - ready = (state == IDLE) && armed.
  - busy = (state != IDLE).
- rw or addr changing after accept has no effect; the captured values are used.
- protocol_err is set at any edge with state != IDLE, valid == 1 and armed == 1. This is a new request edge while busy: valid dropped and was re-raised during the operation. The offending request is dropped, not queued. protocol_err clears only on reset.
- Back-to-back operation: valid low in DONE or IDLE re-arms, so a new accept is possible on the first IDLE cycle. Minimum command spacing = LAT + 2 cycles.
- Read-after-write to the same address returns the new data. The write is committed before the responder re-enters IDLE.

Decomposition:
- Shared package sram_pkg holds:
  - state typedef and encodings (IDLE, RD_WAIT, WR_WAIT, DONE)
  - RW_WRITE=1 and RW_READ=0 constants, shared with the controller FSM
  - default DATA_W and ADDR_W
- Sub-module sram_word_array (parameters DATA_W and ADDR_W):
  - one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata)
  - asynchronous reset clears all words to 0
  - the responder registers the read data itself

Test Plan:
- Reset then idle, valid=0 -> ready=1, busy=0, rdata=0, done=0, protocol_err=0; reset mid-WR_WAIT (addr=1, wdata=0x5A) -> later read of addr 1 returns 0x00.
- Write with WRITE_LAT=1: valid=1, rw=1, addr=2, wdata=0xA5 at edge N -> array[2]=0xA5 at edge N+1; done=1 for one cycle; rdata_valid stays 0.
- Read with READ_LAT=2: read addr 2 at edge N -> rdata=0xA5 after edge N+2; rdata_valid=1 and done=1 together for exactly one cycle; busy=1 from N to N+3.
- Valid held high for 10 cycles with rw=0 -> exactly one read completes; ready stays 0 until valid drops; protocol_err stays 0.
- Valid dropped and re-raised during RD_WAIT -> protocol_err=1 and stays 1; the second request is ignored; the first read completes normally.
- Back-to-back: write 0x3C to addr 3, valid low for one cycle, then read addr 3 -> rdata=0x3C; spacing between the two accepts = WRITE_LAT + 2 = 3 cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM bank responder and the chip-select controller FSM.
package sram_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 2;
   localparam int CNT_W      = 4;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RD_WAIT = 2'b01,
      WR_WAIT = 2'b10,
      DONE    = 2'b11
   } state_t;

   // Counter preload: the access happens LAT edges after accept, the accept edge counts as one.
   function automatic logic [CNT_W-1:0] lat_load(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/sram_bank_responder_if.sv
// rw/valid command bus between the controller FSM (master) and the responder (slave).
interface sram_bank_responder_if #(
   parameter int DATA_W = sram_pkg::DATA_W_DEF,
   parameter int ADDR_W = sram_pkg::ADDR_W_DEF
);
   logic              valid;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic              busy;
   logic [DATA_W-1:0] rdata;
   logic              rdata_valid;
   logic              done;
   logic              protocol_err;

   modport master (
      output valid, rw, addr, wdata,
      input  ready, busy, rdata, rdata_valid, done, protocol_err
   );

   modport slave (
      input  valid, rw, addr, wdata,
      output ready, busy, rdata, rdata_valid, done, protocol_err
   );
endinterface

// File: rtl/sram_word_array.sv
// Small word array: one synchronous write port, one combinational read port, cleared on reset.
module sram_word_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sram_bank_responder.sv
// Memory-side responder: accepts one rw/valid command per valid assertion, waits the
// programmed latency, then performs the access on the word array and strobes done.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for valid with armed set
//   RD_WAIT | read latency countdown; array read at count 0
//   WR_WAIT | write latency countdown; array write at count 0
//   DONE    | one-cycle completion (done, rdata_valid on reads)
module sram_bank_responder
   import sram_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int READ_LAT  = 2,
   parameter int WRITE_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   sram_bank_responder_if.slave  bus
);
   localparam logic [CNT_W-1:0] RD_LOAD = lat_load(READ_LAT);
   localparam logic [CNT_W-1:0] WR_LOAD = lat_load(WRITE_LAT);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              armed_q, armed_d;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              perr_q;

   logic              capture;
   logic              arr_we;
   logic              rd_load;
   logic              perr_set;
   logic [DATA_W-1:0] arr_rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      capture = 1'b0;
      arr_we  = 1'b0;
      rd_load = 1'b0;

      // Any low cycle of valid re-arms; a held valid cannot retrigger.
      if (!bus.valid) armed_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (armed_q && bus.valid) begin
               capture = 1'b1;
               armed_d = 1'b0;
               if (bus.rw == RW_WRITE) begin
                  state_d = WR_WAIT;
                  cnt_d   = WR_LOAD;
               end else begin
                  state_d = RD_WAIT;
                  cnt_d   = RD_LOAD;
               end
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               rd_load = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_WAIT: begin
            if (cnt_q == '0) begin
               arr_we  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A fresh valid edge while busy is flagged and otherwise ignored.
      perr_set = (state_q != IDLE) && bus.valid && armed_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rw_q    <= RW_READ;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (capture) begin
         rw_q    <= bus.rw;
         addr_q  <= bus.addr;
         wdata_q <= bus.wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (rd_load) begin
         rdata_q <= arr_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perr_q <= 1'b0;
      end else if (perr_set) begin
         perr_q <= 1'b1;
      end
   end

   sram_word_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (arr_we),
      .waddr (addr_q),
      .wdata (wdata_q),
      .raddr (addr_q),
      .rdata (arr_rdata)
   );

   assign bus.ready        = (state_q == IDLE) && armed_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.done         = (state_q == DONE);
   assign bus.rdata_valid  = (state_q == DONE) && (rw_q == RW_READ);
   assign bus.rdata        = rdata_q;
   assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_sram_bank_responder.sv
// Directed and randomized checks of sram_bank_responder against a transaction-level memory model.
module tb_sram_bank_responder;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 2;
   localparam int READ_LAT  = 2;
   localparam int WRITE_LAT = 1;

   logic clk = 1'b0;
   logic reset;

   sram_bank_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   sram_bank_responder #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .READ_LAT  (READ_LAT),
      .WRITE_LAT (WRITE_LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [DATA_W-1:0] mdl_mem [2**ADDR_W];
   logic [DATA_W-1:0] mdl_rdata;
   logic              mdl_perr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < 2**ADDR_W; i++) mdl_mem[i] = '0;
      mdl_rdata = '0;
      mdl_perr  = 1'b0;
   endtask

   task automatic do_reset();
      bus.valid = 1'b0;
      reset     = 1'b1;
      tick();
      tick();
      mdl_clear();
      reset = 1'b0;
   endtask

   // One full command; valid is held for 'hold' samples after the accept edge.
   task automatic run_cmd(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int hold, output int acc);
      int lat;
      lat = w ? WRITE_LAT : READ_LAT;
      chk("pre_ready", bus.ready, 1);
      bus.valid = 1'b1;
      bus.rw    = w;
      bus.addr  = a;
      bus.wdata = d;
      tick();
      acc = cyc;
      for (int k = 0; k <= lat + 1; k++) begin
         if (k > 0) tick();
         if (k == lat) begin
            if (w) mdl_mem[a] = d;
            else   mdl_rdata  = mdl_mem[a];
         end
         chk("busy",        bus.busy,         (k <= lat));
         chk("done",        bus.done,         (k == lat));
         chk("rdata_valid", bus.rdata_valid,  (k == lat) && !w);
         chk("rdata",       bus.rdata,        mdl_rdata);
         chk("ready",       bus.ready,        (k == lat + 1) && (hold <= lat));
         chk("perr",        bus.protocol_err, mdl_perr);
         if (k == 0) begin
            bus.rw    = 1'($urandom);
            bus.addr  = ADDR_W'($urandom);
            bus.wdata = DATA_W'($urandom);
         end
         if (k == hold) bus.valid = 1'b0;
      end
      for (int k = lat + 2; k <= hold + 1; k++) begin
         tick();
         chk("hold_ready", bus.ready, (k == hold + 1));
         chk("hold_busy",  bus.busy,  0);
         chk("hold_done",  bus.done,  0);
         if (k == hold) bus.valid = 1'b0;
      end
   endtask

   initial begin
      int acc1, acc2;
      bus.valid = 1'b0;
      bus.rw    = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;
      mdl_clear();
      do_reset();

      chk("rst_ready", bus.ready,        1);
      chk("rst_busy",  bus.busy,         0);
      chk("rst_rdata", bus.rdata,        0);
      chk("rst_done",  bus.done,         0);
      chk("rst_rdv",   bus.rdata_valid,  0);
      chk("rst_perr",  bus.protocol_err, 0);
      tick();
      chk("idle_busy", bus.busy, 0);

      // Reset during WR_WAIT must abort the write.
      bus.valid = 1'b1;
      bus.rw    = 1'b1;
      bus.addr  = 2'd1;
      bus.wdata = 8'h5A;
      tick();
      chk("mid_busy", bus.busy, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy",  bus.busy,  0);
      chk("mid_rst_ready", bus.ready, 1);
      #2;
      reset     = 1'b0;
      bus.valid = 1'b0;
      mdl_clear();
      tick();
      run_cmd(1'b0, 2'd1, 8'h00, 0, acc1);
      chk("abort_rdata", bus.rdata, 8'h00);

      // Write then read back, then a long-held read.
      run_cmd(1'b1, 2'd2, 8'hA5, 0, acc1);
      tick();
      run_cmd(1'b0, 2'd2, 8'h00, 0, acc1);
      chk("rd_a5", bus.rdata, 8'hA5);
      tick();
      run_cmd(1'b0, 2'd2, 8'h00, 10, acc1);
      chk("held_perr", bus.protocol_err, 0);

      // Back-to-back write/read at minimum spacing.
      tick();
      run_cmd(1'b1, 2'd3, 8'h3C, 0, acc1);
      run_cmd(1'b0, 2'd3, 8'h00, 0, acc2);
      chk("b2b_rdata", bus.rdata, 8'h3C);
      chk("b2b_gap",   acc2 - acc1, WRITE_LAT + 2);

      for (int i = 0; i < 25; i++) begin
         run_cmd(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), $urandom_range(0, 12), acc1);
         if ($urandom_range(0, 1) == 1) tick();
      end

      // valid dropped and re-raised during RD_WAIT.
      bus.valid = 1'b1;
      bus.rw    = 1'b0;
      bus.addr  = 2'd2;
      tick();
      chk("pe_busy0", bus.busy, 1);
      bus.valid = 1'b0;
      tick();
      chk("pe_perr1", bus.protocol_err, 0);
      bus.valid = 1'b1;
      bus.addr  = 2'd0;
      tick();
      mdl_rdata = mdl_mem[2];
      mdl_perr  = 1'b1;
      chk("pe_perr2", bus.protocol_err, 1);
      chk("pe_done",  bus.done,         1);
      chk("pe_rdv",   bus.rdata_valid,  1);
      chk("pe_rdata", bus.rdata,        mdl_rdata);
      bus.valid = 1'b0;
      tick();
      chk("pe_busy3",  bus.busy,         0);
      chk("pe_ready3", bus.ready,        1);
      chk("pe_perr3",  bus.protocol_err, 1);
      tick();
      chk("pe_busy4",  bus.busy,         0);
      chk("pe_perr4",  bus.protocol_err, 1);
      run_cmd(1'b0, 2'd2, 8'h00, 1, acc1);

      do_reset();
      chk("final_perr", bus.protocol_err, 0);
      tick();
      run_cmd(1'b0, 2'd2, 8'h00, 0, acc1);
      chk("final_rdata", bus.rdata, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
